// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with PC register, icache handshake and IF/ID latch.
// Define FETCH_SKID_BUF_EN to add a one-entry skid buffer that keeps icache hits taken during stall.
module instr_fetch #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
`ifdef FETCH_SKID_BUF_EN
        , SKID = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_npc_q, ifid_npc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;
`ifdef FETCH_SKID_BUF_EN
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != HALTED) begin
            if (halt) begin
                state_d = HALTED;
`ifdef FETCH_SKID_BUF_EN
            end else if (redirect || flush) begin
                state_d = RUN;
            end else if (state_q == SKID && !stall) begin
                state_d = RUN;
            end else if (state_q == RUN && stall && ihit) begin
                state_d = SKID;
`endif
            end
        end
    end

    always_comb begin
        imemREN  = state_q == RUN;
        imemaddr = pc_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc_q         <= PC_INIT;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_npc_q   <= '0;
            ifid_valid_q <= 1'b0;
`ifdef FETCH_SKID_BUF_EN
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
`endif
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_SKID_BUF_EN
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
`endif
        end
    end

    // Priority below reset: halt, redirect, flush, then stall / fire / bubble.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
`ifdef FETCH_SKID_BUF_EN
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
`endif
        if (state_q != HALTED) begin
            if (halt || redirect || flush) begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = '0;
            end
            if (!halt && redirect) pc_d = {redirect_pc[31:2], 2'b00};
            if (!halt && !redirect && !flush) begin
`ifdef FETCH_SKID_BUF_EN
                if (state_q == SKID) begin
                    if (!stall) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_npc_d   = skid_pc_q + 32'd4;
                        ifid_valid_d = 1'b1;
                    end
                end else
`endif
                if (stall) begin
`ifdef FETCH_SKID_BUF_EN
                    if (ihit) begin
                        skid_instr_d = iload;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_plus4;
                    end
`endif
                end else if (ihit) begin
                    ifid_instr_d = iload;
                    ifid_pc_d    = pc_q;
                    ifid_npc_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                end else begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                end
            end
        end
    end

    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_npc   = ifid_npc_q;
    assign ifid_valid = ifid_valid_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch with PC_INIT=0x40.
// Expected values follow the build; FETCH_SKID_BUF_EN selects the skid-buffer expectations.
module tb_instr_fetch;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(.PC_INIT(32'h0000_0040)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc),
        .ifid_valid(ifid_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic go_to(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; iload = '0; stall = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        step();
        step();
        nRST = 1'b1;
        chk("rst_addr", imemaddr, 32'h40);
        chk("rst_ren", {31'b0, imemREN}, 32'd1);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);

        ihit = 1'b1; iload = 32'h2002_0005;
        step();
        chk("f1_instr", ifid_instr, 32'h2002_0005);
        chk("f1_pc", ifid_pc, 32'h40);
        chk("f1_npc", ifid_npc, 32'h44);
        chk("f1_valid", {31'b0, ifid_valid}, 32'd1);
        chk("f1_addr", imemaddr, 32'h44);
        iload = 32'h0;
        step();
        chk("f2_instr", ifid_instr, 32'h0);
        chk("f2_pc", ifid_pc, 32'h44);
        chk("f2_npc", ifid_npc, 32'h48);
        chk("f2_addr", imemaddr, 32'h48);

        ihit = 1'b0;
        step();
        chk("bub_valid", {31'b0, ifid_valid}, 32'd0);
        chk("bub_pc", ifid_pc, 32'h44);
        chk("bub_npc", ifid_npc, 32'h48);
        chk("bub_addr", imemaddr, 32'h48);

        ihit = 1'b1; iload = 32'hDEAD_BEEF; stall = 1'b1;
        go_to(32'h0000_0103);
        stall = 1'b0;
        chk("redir_addr", imemaddr, 32'h100);
        chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
        chk("redir_instr", ifid_instr, 32'h0);

        iload = 32'h0000_AAAA;
        step();
        chk("pre_fl_valid", {31'b0, ifid_valid}, 32'd1);
        iload = 32'h0000_1111; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, ifid_valid}, 32'd0);
        chk("fl_instr", ifid_instr, 32'h0);
        chk("fl_addr", imemaddr, 32'h104);
        chk("fl_pc", ifid_pc, 32'h100);

        ihit = 1'b0;
        go_to(32'h7C);
        ihit = 1'b1; iload = 32'h77;
        step();
        chk("st_pre_pc", ifid_pc, 32'h7C);
        chk("st_pre_addr", imemaddr, 32'h80);
        stall = 1'b1; iload = 32'h88;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_pc", ifid_pc, 32'h7C);
            chk("st_hold_instr", ifid_instr, 32'h77);
            chk("st_hold_valid", {31'b0, ifid_valid}, 32'd1);
`ifdef FETCH_SKID_BUF_EN
            chk("st_addr", imemaddr, 32'h84);
            chk("st_ren", {31'b0, imemREN}, 32'd0);
`else
            chk("st_addr", imemaddr, 32'h80);
            chk("st_ren", {31'b0, imemREN}, 32'd1);
`endif
        end
        stall = 1'b0;
        step();
        chk("st_rel_pc", ifid_pc, 32'h80);
        chk("st_rel_npc", ifid_npc, 32'h84);
        chk("st_rel_instr", ifid_instr, 32'h88);
        chk("st_rel_valid", {31'b0, ifid_valid}, 32'd1);
        chk("st_rel_addr", imemaddr, 32'h84);
        chk("st_rel_ren", {31'b0, imemREN}, 32'd1);

        ihit = 1'b0;
        go_to(32'hFFFF_FFFC);
        ihit = 1'b1; iload = 32'h99;
        step();
        chk("wrap_addr", imemaddr, 32'h0);
        chk("wrap_npc", ifid_npc, 32'h0);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);

        ihit = 1'b0;
        go_to(32'h4C);
        ihit = 1'b1; iload = 32'h55;
        step();
        chk("h_pre_addr", imemaddr, 32'h50);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("h_ren", {31'b0, imemREN}, 32'd0);
        chk("h_addr", imemaddr, 32'h50);
        chk("h_valid", {31'b0, ifid_valid}, 32'd0);
        chk("h_instr", ifid_instr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h200; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("h_frz_addr", imemaddr, 32'h50);
            chk("h_frz_ren", {31'b0, imemREN}, 32'd0);
        end
        redirect = 1'b0; flush = 1'b0;
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        chk("h_rst_addr", imemaddr, 32'h40);
        chk("h_rst_ren", {31'b0, imemREN}, 32'd1);
        chk("h_rst_pc", ifid_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
